fpga_tick_gen: RTL

FPGA_TICK_GEN -- requirements
Module: fpga_tick_gen

---
 rtl/fpga_tick_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/fpga_tick_gen.sv
// fpga_tick_gen: NCH independent clock dividers, each producing a 50% duty clk_out and a one-cycle tick.
// New divide values are staged in a shadow register and only take effect at a period boundary.
module fpga_tick_gen #(
  parameter int NCH         = 2,
  parameter int CW          = 24,
  parameter int DEFAULT_DIV = 125000
) (
  input  logic              clk25mhz,
  input  logic              reset_n,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH-1:0]    div_load,
  input  logic [NCH*CW-1:0] div_in,
  input  logic              sync,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH*CW-1:0] div_active
);

  localparam logic [CW-1:0] RESET_DIV = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] ONE       = CW'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] active_div;
    logic [CW-1:0] active_nxt;
    logic [CW-1:0] shadow_div;
    logic [CW-1:0] shadow_nxt;
    logic          pending;
    logic          pending_nxt;
    logic          clk_q;
    logic          clk_nxt;
    logic          tick_q;
    logic          tick_nxt;
    logic [CW-1:0] load_val;
    logic          load_ok;
    logic          terminal;

    assign load_val = div_in[i*CW +: CW];
    assign load_ok  = div_load[i] && (load_val != '0);
    // active_div is never zero, so the subtraction cannot wrap; >= keeps cnt bounded regardless
    assign terminal = (cnt >= (active_div - ONE));

    always_comb begin
      cnt_nxt     = cnt;
      active_nxt  = active_div;
      shadow_nxt  = shadow_div;
      pending_nxt = pending;
      clk_nxt     = clk_q;
      tick_nxt    = 1'b0;

      if (!enable[i]) begin
        cnt_nxt = '0;
        if (load_ok) begin
          active_nxt  = load_val;
          pending_nxt = 1'b0;
        end
      end else begin
        if (sync) begin
          cnt_nxt = '0;
          clk_nxt = 1'b0;
        end else if (terminal) begin
          cnt_nxt  = '0;
          tick_nxt = 1'b1;
          clk_nxt  = ~clk_q;
          if (pending) begin
            active_nxt  = shadow_div;
            pending_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end

        // A load arriving on a boundary edge is staged for the following boundary
        if (load_ok) begin
          shadow_nxt  = load_val;
          pending_nxt = 1'b1;
        end
      end
    end

    always_ff @(posedge clk25mhz or negedge reset_n) begin
      if (!reset_n) begin
        cnt        <= '0;
        active_div <= RESET_DIV;
        shadow_div <= RESET_DIV;
        pending    <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt        <= cnt_nxt;
        active_div <= active_nxt;
        shadow_div <= shadow_nxt;
        pending    <= pending_nxt;
        clk_q      <= clk_nxt;
        tick_q     <= tick_nxt;
      end
    end

    assign clk_out[i]              = clk_q;
    assign tick[i]                 = tick_q;
    assign div_active[i*CW +: CW]  = active_div;
  end

endmodule
